// File: rtl/counter_mod_nbits.sv
// Up/down counter with programmable modulo, parallel load, wrap or
// saturate limits, cascadable terminal count and sticky overflow.
module counter_mod_nbits #(
  parameter int unsigned      nBits    = 27,
  parameter logic [nBits-1:0] maxCount = {nBits{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [nBits-1:0] loadValue,
  input  logic             clearOvf,
  output logic [nBits-1:0] counter,
  output logic             tc,
  output logic             overflow
);

  logic [nBits-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             at_max;
  logic             at_min;
  logic             term;

  assign at_max = (cnt_q == maxCount);
  assign at_min = (cnt_q == '0);

  assign tc   = en & ((up & at_max) | (~up & at_min));
  assign term = tc & ~load;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = term | (ovf_q & ~clearOvf);
    if (load) begin
      cnt_d = (loadValue > maxCount) ? maxCount : loadValue;
    end else if (en) begin
      if (up) begin
        if (!at_max)       cnt_d = cnt_q + 1'b1;
        else if (SATURATE) cnt_d = maxCount;
        else               cnt_d = '0;
      end else begin
        if (!at_min)       cnt_d = cnt_q - 1'b1;
        else if (SATURATE) cnt_d = '0;
        else               cnt_d = maxCount;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign counter  = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_counter_mod_nbits.sv
// Directed bench: vector table for wrap mode, plus saturate,
// two-stage cascade and mid-count reset sequences.
module tb_counter_mod_nbits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // wrap-mode instance, 4 bits, modulo 10
  logic       m_rst, m_en, m_up, m_load, m_clr;
  logic [3:0] m_lv, m_cnt;
  logic       m_tc, m_ovf;

  counter_mod_nbits #(.nBits(4), .maxCount(4'd9), .SATURATE(1'b0)) u_main (
    .clk(clk), .rst(m_rst), .en(m_en), .up(m_up), .load(m_load),
    .loadValue(m_lv), .clearOvf(m_clr),
    .counter(m_cnt), .tc(m_tc), .overflow(m_ovf)
  );

  // saturate-mode instance
  logic       s_rst, s_en, s_up, s_load, s_clr;
  logic [3:0] s_lv, s_cnt;
  logic       s_tc, s_ovf;

  counter_mod_nbits #(.nBits(4), .maxCount(4'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .up(s_up), .load(s_load),
    .loadValue(s_lv), .clearOvf(s_clr),
    .counter(s_cnt), .tc(s_tc), .overflow(s_ovf)
  );

  // two-stage decimal cascade
  logic       c_rst, c_en, c_up, c_load, c_clr;
  logic [3:0] c_lv, c0_cnt, c1_cnt;
  logic       tc0, tc1, ovf0, ovf1;

  counter_mod_nbits #(.nBits(4), .maxCount(4'd9)) u_c0 (
    .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load),
    .loadValue(c_lv), .clearOvf(c_clr),
    .counter(c0_cnt), .tc(tc0), .overflow(ovf0)
  );

  counter_mod_nbits #(.nBits(4), .maxCount(4'd9)) u_c1 (
    .clk(clk), .rst(c_rst), .en(tc0), .up(c_up), .load(c_load),
    .loadValue(c_lv), .clearOvf(c_clr),
    .counter(c1_cnt), .tc(tc1), .overflow(ovf1)
  );

  // default-width instance
  logic        b_rst, b_en, b_up, b_load, b_clr;
  logic [26:0] b_lv, b_cnt;
  logic        b_tc, b_ovf;

  counter_mod_nbits u_big (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
    .loadValue(b_lv), .clearOvf(b_clr),
    .counter(b_cnt), .tc(b_tc), .overflow(b_ovf)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic       clr;
    logic       ctc;
    logic       etc;
    logic [3:0] ecnt;
    logic       eovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic en, logic up,
                              logic load, logic [3:0] lv, logic clr,
                              logic ctc, logic etc,
                              logic [3:0] ecnt, logic eovf);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.load = load;
    v.lv = lv; v.clr = clr; v.ctc = ctc; v.etc = etc;
    v.ecnt = ecnt; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    m_rst = 0; m_en = 0; m_up = 0; m_load = 0; m_clr = 0; m_lv = 0;
    s_rst = 0; s_en = 0; s_up = 0; s_load = 0; s_clr = 0; s_lv = 0;
    c_rst = 0; c_en = 0; c_up = 1; c_load = 0; c_clr = 0; c_lv = 0;
    b_rst = 0; b_en = 0; b_up = 1; b_load = 0; b_clr = 0; b_lv = 0;

    // rst en up ld lv clr | ctc etc cnt ovf
    vq.push_back(mk(0, 1, 1, 1, 4'd5, 0,  0, 0, 4'd0, 0));
    vq.push_back(mk(0, 1, 1, 1, 4'd5, 0,  1, 0, 4'd0, 0));
    for (int i = 0; i < 9; i++)
      vq.push_back(mk(1, 1, 1, 0, 4'd0, 0,
                      1, 0, 4'(i + 1), 0));
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 0,  1, 1, 4'd0, 1));
    // load 0 while counting down: tc visible, no overflow change
    vq.push_back(mk(1, 1, 0, 1, 4'd0, 0,  1, 1, 4'd0, 1));
    vq.push_back(mk(1, 1, 0, 0, 4'd0, 0,  1, 1, 4'd9, 1));
    vq.push_back(mk(1, 1, 0, 0, 4'd0, 0,  1, 0, 4'd8, 1));
    vq.push_back(mk(1, 1, 0, 0, 4'd0, 0,  1, 0, 4'd7, 1));
    vq.push_back(mk(1, 0, 0, 0, 4'd0, 1,  1, 0, 4'd7, 0));
    // clamped load with en high
    vq.push_back(mk(1, 1, 1, 1, 4'd15, 0, 1, 0, 4'd9, 0));
    // set and clear on the same edge
    vq.push_back(mk(1, 1, 1, 0, 4'd0, 1,  1, 1, 4'd0, 1));
    vq.push_back(mk(1, 0, 1, 0, 4'd0, 0,  1, 0, 4'd0, 1));
    vq.push_back(mk(1, 0, 0, 1, 4'd12, 0, 1, 0, 4'd9, 1));
    vq.push_back(mk(1, 0, 0, 1, 4'd3, 0,  1, 0, 4'd3, 1));
    vq.push_back(mk(1, 1, 0, 1, 4'd10, 1, 1, 0, 4'd9, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      m_rst = vq[i].rst; m_en = vq[i].en; m_up = vq[i].up;
      m_load = vq[i].load; m_lv = vq[i].lv; m_clr = vq[i].clr;
      #1;
      if (vq[i].ctc) chk($sformatf("v%0d tc", i), 32'(m_tc), 32'(vq[i].etc));
      @(posedge clk); #1;
      chk($sformatf("v%0d cnt", i), 32'(m_cnt), 32'(vq[i].ecnt));
      chk($sformatf("v%0d ovf", i), 32'(m_ovf), 32'(vq[i].eovf));
    end

    // saturate: load 8, up 4 cycles, down 10 cycles
    @(negedge clk);
    s_rst = 1; s_load = 1; s_lv = 4'd8;
    @(posedge clk); #1;
    chk("sat load", 32'(s_cnt), 32'd8);
    @(negedge clk);
    s_load = 0; s_en = 1; s_up = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat up%0d", k), 32'(s_cnt), 32'd9);
    end
    chk("sat ovf", 32'(s_ovf), 32'd1);
    @(negedge clk);
    s_up = 0; s_clr = 1;
    @(posedge clk); #1;
    chk("sat dn0", 32'(s_cnt), 32'd8);
    chk("sat clr", 32'(s_ovf), 32'd0);
    @(negedge clk);
    s_clr = 0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat dn%0d", k), 32'(s_cnt),
          (k >= 9) ? 32'd0 : 32'(9 - k));
    end
    chk("sat hold ovf", 32'(s_ovf), 32'd1);
    chk("sat tc at 0", 32'(s_tc), 32'd1);

    // cascade 00..99 then 00
    @(negedge clk);
    c_rst = 0;
    @(posedge clk); #1;
    chk("casc rst", 32'({c1_cnt, c0_cnt}), 32'h00);
    @(negedge clk);
    c_rst = 1; c_en = 1;
    for (int n = 0; n < 100; n++) begin
      #1;
      chk($sformatf("casc tc1@%0d", n), 32'(tc1), 32'(n == 99));
      @(posedge clk); #1;
      chk($sformatf("casc val%0d", n + 1),
          32'(c1_cnt) * 10 + 32'(c0_cnt), 32'((n + 1) % 100));
      @(negedge clk);
    end
    c_en = 0;

    // default width: count to 1000, reset, resume
    @(negedge clk);
    b_rst = 1; b_en = 1;
    repeat (1000) @(posedge clk);
    #1;
    chk("big 1000", 32'(b_cnt), 32'd1000);
    @(negedge clk);
    b_rst = 0; b_clr = 0;
    @(posedge clk); #1;
    chk("big rst cnt", 32'(b_cnt), 32'd0);
    chk("big rst ovf", 32'(b_ovf), 32'd0);
    @(negedge clk);
    b_rst = 1;
    @(posedge clk); #1;
    chk("big resume", 32'(b_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_mod_nbits.md
# counter_mod_nbits

Parametrised synchronous up/down counter with programmable modulo, parallel load, wrap or saturate mode, a cascadable terminal-count output and a sticky overflow flag. It replaces the fixed free-running N-bit T-flip-flop counter wherever a design needs direction control, a count limit other than 2^nBits, or chaining into wider or multi-stage timers such as clock dividers, debounce timers and display multiplexers.

## Interface
- nBits, 27, counter width in bits (1..32)
- maxCount, 2^nBits-1, highest count value; legal range 1..2^nBits-1
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, synchronous, active-low
- en  input  1  count enable; one step per clk edge while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe
- loadValue  input  nBits  value written on load
- clearOvf  input  1  clears the sticky overflow flag
- counter  output  nBits  current count, registered
- tc  output  1  terminal count, combinational, for cascading
- overflow  output  1  sticky wrap/saturation flag, registered

## Operation
- Reset: clk edge with rst=0 sets counter=0 and overflow=0. Reset overrides every other input.
- Priority at each edge when rst=1: load, then en. Inputs up and en are ignored on a load cycle.
- Load: counter <= min(loadValue, maxCount). An out-of-range load clamps to maxCount. A load never sets overflow.
- Count up (en=1, up=1):
  - counter < maxCount: counter+1.
  - counter == maxCount: 0 if SATURATE=0; maxCount held if SATURATE=1.
- Count down (en=1, up=0):
  - counter > 0: counter-1.
  - counter == 0: maxCount if SATURATE=0; 0 held if SATURATE=1.
- en=0 and load=0: counter holds.
- Terminal event: en=1 and load=0 and ((up=1 and counter==maxCount) or (up=0 and counter==0)).
- tc = en & ((up & counter==maxCount) | (~up & counter==0)).
  - tc is combinational and is not gated by load.
  - For cascading, a following stage's en is driven from this stage's tc.
- overflow:
  - Set to 1 on the edge that completes a terminal event, in both wrap and saturate modes.
  - Cleared by clearOvf=1 when no terminal event occurs on the same edge.
  - If set and clear occur on the same edge, set wins.
- All arithmetic is modulo 2^nBits internally. Comparisons are unsigned. Counter never leaves 0..maxCount after reset.

## Timing
- Latency: counter reflects load, step or reset one clk edge after the inputs are sampled.
- tc changes in the same cycle as en, up or counter change, with no register stage. A chain of k stages has a k-deep combinational tc path, and the integrator budgets for it.
- overflow rises on the same edge that counter wraps or saturates.
- Reset mid-count: the next edge gives counter=0 and overflow=0 regardless of en, load or clearOvf. tc then evaluates from counter=0, so it is high if en=1 and up=0.
- No handshake. Inputs must be stable around the clk edge and come from the clk domain.

## Test plan
- Reset: rst=0 for 2 cycles with en=1, load=1, loadValue=5 -> counter=0, overflow=0. Release rst with nBits=4, maxCount=9, en=1, up=1 -> counter reads 1,2,…,9,0. tc=1 only while counter=9. overflow=1 from the edge that wraps to 0.
- Down wrap: nBits=4, maxCount=9, load 0, then en=1, up=0 -> counter 9,8,7. tc=1 during the counter=0 cycle. Pulse clearOvf -> overflow returns to 0 on the next edge.
- Saturate: SATURATE=1, maxCount=9, load 8, en=1, up=1 for 4 cycles -> counter 9,9,9,9 and overflow=1. Then up=0 for 10 cycles -> counter reaches 0 and holds.
- Load priority and clamp: load=1 with en=1, loadValue=15, maxCount=9 -> counter=9, overflow unchanged. Same-edge clearOvf=1 plus a terminal event -> overflow stays 1.
- Cascade: two instances, nBits=4, maxCount=9, stage-1 en tied to stage-0 tc, en0=1 for 100 cycles from reset -> {stage1,stage0} counts 00..99 then 00. Stage-1 tc=1 only at 99.
- Reset mid-operation: nBits=27 default, count to 1000, assert rst=0 for 1 cycle -> counter=0, overflow=0 next edge. Counting resumes from 1 after release.
